// File: rtl/fios_res_collector.sv
// Result collector for the FIOS Montgomery multiplier. It assembles the serial 17-bit RES words,
// optionally subtracts p once with a word-serial borrow chain, and presents the result with valid/ready.
module fios_res_collector #(
  parameter int unsigned s         = 8,
  parameter bit          FINAL_SUB = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [s*17-1:0]   p_i,
  input  logic              res_valid_i,
  input  logic [16:0]       res_i,
  output logic [s*17-1:0]   res_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              busy_o,
  output logic              error_o
);

  localparam int unsigned W    = 17;
  localparam int unsigned CntW = $clog2(s) + 1;
  localparam int unsigned IdxW = (s > 1) ? $clog2(s) : 1;

  typedef enum logic [1:0] {StIdle, StCollect, StSub, StHold} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                borrow_q, borrow_d;
  logic                err_q, err_d;
  logic [s*W-1:0]      res_q, res_d;
  logic [W-1:0]        words_q [s];
  logic [W-1:0]        p_q     [s];
  logic [W-1:0]        diff_q  [s];

  logic                wr_word, wr_diff, ld_p, last;
  logic [IdxW-1:0]     idx, wr_idx;
  logic [W:0]          sub_full;
  logic [s*W-1:0]      word_vec, coll_vec, diff_vec;

  assign idx  = cnt_q[IdxW-1:0];
  assign last = (idx == IdxW'(s - 1));

  // One word of the borrow chain; bit W is the borrow out.
  assign sub_full = {1'b0, words_q[idx]} - {1'b0, p_q[idx]} - {{W{1'b0}}, borrow_q};

  // Candidate results: the word currently being produced is taken from the live path.
  always_comb begin
    word_vec = '0;
    coll_vec = '0;
    diff_vec = '0;
    for (int unsigned k = 0; k < s; k++) begin
      word_vec[k*W+:W] = words_q[k];
      coll_vec[k*W+:W] = (k == s - 1) ? res_i : words_q[k];
      diff_vec[k*W+:W] = (k == s - 1) ? sub_full[W-1:0] : diff_q[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    res_d    = res_q;
    wr_word  = 1'b0;
    wr_diff  = 1'b0;
    ld_p     = 1'b0;
    wr_idx   = idx;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          ld_p    = 1'b1;
          cnt_d   = '0;
          state_d = StCollect;
          if (res_valid_i) begin
            wr_word = 1'b1;
            wr_idx  = '0;
            cnt_d   = CntW'(1);
          end
        end else if (res_valid_i) begin
          err_d = 1'b1;
        end
      end
      StCollect: begin
        if (start_i) err_d = 1'b1;
        if (res_valid_i) begin
          wr_word = 1'b1;
          cnt_d   = cnt_q + CntW'(1);
          if (last) begin
            if (FINAL_SUB) begin
              state_d  = StSub;
              cnt_d    = '0;
              borrow_d = 1'b0;
            end else begin
              state_d = StHold;
              res_d   = coll_vec;
            end
          end
        end
      end
      StSub: begin
        if (start_i || res_valid_i) err_d = 1'b1;
        wr_diff  = 1'b1;
        borrow_d = sub_full[W];
        cnt_d    = cnt_q + CntW'(1);
        if (last) begin
          state_d = StHold;
          // Final borrow set means result < p: keep the original words.
          res_d   = sub_full[W] ? word_vec : diff_vec;
        end
      end
      StHold: begin
        if (res_valid_i) err_d = 1'b1;
        if (res_ready_i) begin
          if (start_i) begin
            ld_p    = 1'b1;
            cnt_d   = '0;
            state_d = StCollect;
          end else begin
            state_d = StIdle;
          end
        end else if (start_i) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
      for (int unsigned k = 0; k < s; k++) begin
        words_q[k] <= '0;
        p_q[k]     <= '0;
        diff_q[k]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      res_q    <= res_d;
      if (wr_word) words_q[wr_idx] <= res_i;
      if (wr_diff) diff_q[idx] <= sub_full[W-1:0];
      if (ld_p) begin
        for (int unsigned k = 0; k < s; k++) p_q[k] <= p_i[k*W+:W];
      end
    end
  end

  assign res_o       = res_q;
  assign res_valid_o = (state_q == StHold);
  assign busy_o      = (state_q != StIdle);
  assign error_o     = err_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Bench for fios_res_collector: s=2 with final subtraction against a transaction-level model,
// plus an s=8 pass-through instance driven with directed words.
module tb_fios_res_collector;

  localparam int unsigned SA = 2;
  localparam int unsigned SB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             a_start = 0, a_valid = 0, a_ready = 0;
  logic [16:0]      a_res = '0;
  logic [SA*17-1:0] a_p = '0;
  logic [SA*17-1:0] a_res_o;
  logic             a_valid_o, a_busy_o, a_err_o;

  logic             b_start = 0, b_valid = 0, b_ready = 0;
  logic [16:0]      b_res = '0;
  logic [SB*17-1:0] b_p = '0;
  logic [SB*17-1:0] b_res_o;
  logic             b_valid_o, b_busy_o, b_err_o;

  fios_res_collector #(.s(SA), .FINAL_SUB(1'b1)) u_dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(a_start), .p_i(a_p), .res_valid_i(a_valid),
    .res_i(a_res), .res_o(a_res_o), .res_valid_o(a_valid_o), .res_ready_i(a_ready),
    .busy_o(a_busy_o), .error_o(a_err_o)
  );

  fios_res_collector #(.s(SB), .FINAL_SUB(1'b0)) u_dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(b_start), .p_i(b_p), .res_valid_i(b_valid),
    .res_i(b_res), .res_o(b_res_o), .res_valid_o(b_valid_o), .res_ready_i(b_ready),
    .busy_o(b_busy_o), .error_o(b_err_o)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of DUT A: phase 0 idle, 1 collecting, 2 subtracting, 3 holding.
  int          m_phase = 0, m_cnt = 0, m_left = 0;
  logic [16:0] m_w [SA];
  logic [33:0] m_p = '0, m_res = '0, m_val;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_left = 0; m_p = '0; m_res = '0; m_err = 1'b0;
      m_w[0] = '0; m_w[1] = '0;
    end else begin
      case (m_phase)
        0: begin
          if (a_start) begin
            m_p = a_p; m_cnt = 0; m_phase = 1;
            if (a_valid) begin m_w[0] = a_res; m_cnt = 1; end
          end else if (a_valid) m_err = 1'b1;
        end
        1: begin
          if (a_start) m_err = 1'b1;
          if (a_valid) begin
            m_w[m_cnt] = a_res;
            m_cnt++;
            if (m_cnt == SA) begin m_phase = 2; m_left = SA; end
          end
        end
        2: begin
          if (a_start || a_valid) m_err = 1'b1;
          m_left--;
          if (m_left == 0) begin
            m_val   = {m_w[1], m_w[0]};
            m_res   = (m_val >= m_p) ? m_val - m_p : m_val;
            m_phase = 3;
          end
        end
        default: begin
          if (a_valid) m_err = 1'b1;
          if (a_ready) begin
            if (a_start) begin m_p = a_p; m_cnt = 0; m_phase = 1; end
            else m_phase = 0;
          end else if (a_start) m_err = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_valid", a_valid_o, m_phase == 3);
      chk("a_busy", a_busy_o, m_phase != 0);
      chk("a_err", a_err_o, m_err);
      chk("a_res", a_res_o, m_res);
    end
  end

  task automatic send_a(input logic [16:0] w);
    a_valid = 1'b1; a_res = w;
    cyc();
    a_valid = 1'b0;
  endtask

  task automatic start_a(input logic [33:0] p);
    a_p = p; a_start = 1'b1;
    cyc();
    a_start = 1'b0;
  endtask

  task automatic release_a();
    a_ready = 1'b1;
    cyc();
    a_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r1, r2, r3;
    logic        ill;
    logic [16:0] wv;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    chk("reset_res", a_res_o, 34'h0);
    chk("reset_flags", {a_valid_o, a_busy_o, a_err_o}, 3'b000);

    // Pass-through instance: eight words with idle gaps, valid one cycle after the last.
    b_p = '1; b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    for (int k = 0; k < SB; k++) begin
      repeat ($urandom_range(0, 3)) cyc();
      wv = 17'(k + 1);
      b_res = wv; b_valid = 1'b1;
      cyc();
      b_valid = 1'b0;
      chk("b_latency", b_valid_o, k == SB - 1);
    end
    for (int k = 0; k < SB; k++) begin
      wv = 17'(k + 1);
      chk("b_word", b_res_o[k*17+:17], wv);
    end
    b_ready = 1'b1;
    cyc();
    b_ready = 1'b0;
    chk("b_release", {b_valid_o, b_busy_o, b_err_o}, 3'b000);

    // 0x20005 - 0x20003 = 2, valid three cycles after the last word.
    start_a({17'h1, 17'h3});
    send_a(17'h5);
    send_a(17'h1);
    chk("t1_lat0", a_valid_o, 1'b0);
    cyc();
    chk("t1_lat1", a_valid_o, 1'b0);
    cyc();
    chk("t1_lat2", a_valid_o, 1'b1);
    chk("t1_res", a_res_o, 34'h00002);
    repeat (3) cyc();
    chk("t1_held", {a_valid_o, a_res_o}, {1'b1, 34'h00002});
    release_a();
    chk("t1_release", {a_valid_o, a_busy_o}, 2'b00);

    // Value below p passes unchanged.
    start_a({17'h1, 17'h3});
    send_a(17'h2);
    send_a(17'h1);
    repeat (2) cyc();
    chk("t2_res", a_res_o, {17'h1, 17'h2});
    release_a();

    // start and first word in the same cycle.
    a_p = {17'h0, 17'h5}; a_start = 1'b1; a_valid = 1'b1; a_res = 17'h7;
    cyc();
    a_start = 1'b0; a_valid = 1'b0;
    send_a(17'h0);
    repeat (2) cyc();
    chk("t3_res", a_res_o, 34'h2);
    release_a();

    // Protocol errors are flagged but ignored.
    chk("t4_err_pre", a_err_o, 1'b0);
    start_a({17'h0, 17'h4});
    send_a(17'h3);
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    chk("t4_err_start", a_err_o, 1'b1);
    send_a(17'h1);
    repeat (2) cyc();
    send_a(17'h1abcd);
    chk("t4_res", {a_valid_o, a_err_o, a_res_o}, {1'b1, 1'b1, 34'h1ffff});

    // Back-to-back: ready and start together with a new p.
    a_ready = 1'b1; a_start = 1'b1; a_p = {17'h2, 17'h10};
    cyc();
    a_ready = 1'b0; a_start = 1'b0;
    chk("t5_no_idle", {a_busy_o, a_valid_o}, 2'b10);
    send_a(17'h8);
    send_a(17'h3);
    repeat (2) cyc();
    chk("t5_res", a_res_o, 34'h1fff8);
    release_a();

    // Reset mid-subtraction.
    start_a({17'h1, 17'h3});
    send_a(17'h9);
    send_a(17'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_reset", {a_valid_o, a_busy_o, a_err_o, a_res_o}, 37'h0);
    start_a({17'h1, 17'h3});
    send_a(17'h5);
    send_a(17'h1);
    repeat (2) cyc();
    chk("t6_rerun", {a_valid_o, a_res_o}, {1'b1, 34'h2});
    release_a();

    // Randomized traffic, mostly legal with occasional protocol errors and resets.
    for (int i = 0; i < 3000; i++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      ill     = ($urandom_range(0, 99) < 4);
      rst     = ($urandom_range(0, 299) == 0);
      a_res   = r1[16:0];
      a_p     = {r2[16:0], r3[16:0]};
      a_ready = ($urandom_range(0, 2) == 0);
      case (m_phase)
        0: begin
          a_start = ($urandom_range(0, 3) == 0);
          a_valid = a_start ? r1[20] : ill;
        end
        1: begin a_start = ill; a_valid = r1[21]; end
        2: begin a_start = ill; a_valid = ($urandom_range(0, 99) < 4); end
        default: begin
          a_start = a_ready ? r1[22] : ill;
          a_valid = ($urandom_range(0, 99) < 3);
        end
      endcase
      cyc();
    end
    a_start = 1'b0; a_valid = 1'b0; a_ready = 1'b0; rst = 1'b0;
    cyc();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
